// File: rtl/buzzer_pkg.sv
// Shared types, pattern table and helpers for the buzzer sequencer.
// Pattern fields are {half-period in clk, on ticks, off ticks, bursts}.
package buzzer_pkg;

  localparam int HALF_W = 16;
  localparam int TIME_W = 12;
  localparam int REPS_W = 4;
  localparam int NPAT   = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ON,
    S_OFF,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [HALF_W-1:0] half;
    logic [TIME_W-1:0] on_t;
    logic [TIME_W-1:0] off_t;
    logic [REPS_W-1:0] reps;
  } pat_t;

  localparam pat_t PAT [0:NPAT-1] = '{
    '{16'd4, 12'd1, 12'd1, 4'd1},
    '{16'd3, 12'd2, 12'd1, 4'd2},
    '{16'd5, 12'd3, 12'd2, 4'd2},
    '{16'd2, 12'd2, 12'd0, 4'd3},
    '{16'd6, 12'd1, 12'd1, 4'd2},
    '{16'd7, 12'd2, 12'd0, 4'd1},
    '{16'd8, 12'd1, 12'd2, 4'd3},
    '{16'd9, 12'd3, 12'd1, 4'd1}
  };

  function automatic logic [IDX_W-1:0] lowest_idx(
    input logic [NPAT-1:0] v
  );
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NPAT-1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [NPAT-1:0] onehot(
    input logic [IDX_W-1:0] i
  );
    logic [NPAT-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/buzzer_tone.sv
// Tick prescaler and square-tone generator; both restart on a phase entry.
// sound starts high on a restart with en set and toggles every half clocks.
module buzzer_tone
  import buzzer_pkg::*;
#(
  parameter int TICK_DIV = 50_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              en,
  input  logic [HALF_W-1:0] half,
  output logic              tick,
  output logic              sound
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]     pre_q, pre_d;
  logic [HALF_W-1:0] tone_q, tone_d;
  logic              snd_q, snd_d;
  logic              wrap;

  assign tick  = (pre_q == PRE_MAX);
  assign wrap  = (tone_q == half - HALF_W'(1));
  assign sound = snd_q;

  always_comb begin
    pre_d  = tick ? '0 : pre_q + PW'(1);
    tone_d = tone_q;
    snd_d  = 1'b0;
    if (restart) begin
      pre_d  = '0;
      tone_d = '0;
      snd_d  = en;
    end else if (en) begin
      tone_d = wrap ? '0 : tone_q + HALF_W'(1);
      snd_d  = wrap ? ~snd_q : snd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      tone_q <= '0;
      snd_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tone_q <= tone_d;
      snd_q  <= snd_d;
    end
  end

endmodule

// File: rtl/buzzer_sequencer.sv
// Fixed-priority arbiter and burst sequencer driving one piezo buzzer.
// Define BUZZER_PREEMPT_EN to let a higher-priority req abort a pattern.
module buzzer_sequencer
  import buzzer_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TICK_DIV = 50_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            done,
  output logic            sound
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [TIME_W-1:0] ph_q, ph_d;
  logic [REPS_W-1:0] reps_q, reps_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [NPAT-1:0]   req_w;
  logic [IDX_W-1:0]  low;
  logic              any;
  logic              preempt;
  logic              restart;
  logic              tone_en;
  logic              tick;

  assign req_w = NPAT'(req);
  assign low   = lowest_idx(req_w);
  assign any   = |req;

`ifdef BUZZER_PREEMPT_EN
  assign preempt = |(req_w & (onehot(owner_q) - NPAT'(1)));
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ph_d    = ph_q;
    reps_d  = reps_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (any) state_d = S_ARB;
      end
      S_ARB: begin
        if (any) begin
          owner_d = low;
          grant_d = NREQ'(onehot(low));
          ph_d    = PAT[low].on_t;
          reps_d  = PAT[low].reps;
          restart = 1'b1;
          state_d = S_ON;
        end else begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      S_ON: begin
        if (tick) begin
          if (ph_q == TIME_W'(1)) begin
            if (reps_q > REPS_W'(1)) begin
              reps_d  = reps_q - REPS_W'(1);
              restart = 1'b1;
              if (PAT[owner_q].off_t == '0) begin
                ph_d = PAT[owner_q].on_t;
              end else begin
                ph_d    = PAT[owner_q].off_t;
                state_d = S_OFF;
              end
            end else begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end else begin
            ph_d = ph_q - TIME_W'(1);
          end
        end
      end
      S_OFF: begin
        if (tick) begin
          if (ph_q == TIME_W'(1)) begin
            ph_d    = PAT[owner_q].on_t;
            restart = 1'b1;
            state_d = S_ON;
          end else begin
            ph_d = ph_q - TIME_W'(1);
          end
        end
      end
      S_DONE: begin
        grant_d = '0;
        // A waiting request skips IDLE so a re-grant lands 2 cycles after done.
        state_d = any ? S_ARB : S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
    if (preempt && (state_q == S_ON || state_q == S_OFF)) begin
      state_d = S_ARB;
      grant_d = NREQ'(onehot(low));
      ph_d    = ph_q;
      reps_d  = reps_q;
      done_d  = 1'b0;
      restart = 1'b0;
    end
  end

  assign tone_en = (state_d == S_ON);

  // The ARB cycle straight after IDLE is not yet an active pattern.
  assign busy_d = (state_d != S_IDLE) && (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ph_q    <= '0;
      reps_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ph_q    <= ph_d;
      reps_q  <= reps_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  buzzer_tone #(
    .TICK_DIV(TICK_DIV)
  ) u_tone (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .en     (tone_en),
    .half   (PAT[owner_q].half),
    .tick   (tick),
    .sound  (sound)
  );

  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Scoreboard bench for buzzer_sequencer: expected grant tenures are queued
// at stimulus time and checked by a monitor against a pattern-level model.
module tb_buzzer_sequencer;

  localparam int TD = 10;

  localparam int T_HALF [4] = '{4, 3, 5, 2};
  localparam int T_ON   [4] = '{1, 2, 3, 2};
  localparam int T_OFF  [4] = '{1, 1, 2, 0};
  localparam int T_REPS [4] = '{1, 2, 2, 3};

  typedef struct {
    int owner;
    int start;
    int fin;
    bit abrt;
    int lead;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic       busy;
  logic       done;
  logic       sound;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  bit   sq[$];
  logic [3:0] cur_g = '0;
  int   st = 0;
  int   busy_bad = 0;

  buzzer_sequencer #(
    .NREQ    (4),
    .TICK_DIV(TD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .grant(grant),
    .busy (busy),
    .done (done),
    .sound(sound)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int plen(input int o);
    return (T_REPS[o] * T_ON[o] + (T_REPS[o] - 1) * T_OFF[o]) * TD;
  endfunction

  function automatic bit snd_m(input int o, input int k);
    int per;
    int r;
    if (k < 0 || k >= plen(o)) return 1'b0;
    per = (T_ON[o] + T_OFF[o]) * TD;
    r   = k % per;
    if (r >= T_ON[o] * TD) return 1'b0;
    return ((r / T_HALF[o]) % 2) == 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int o, input int s, input int f,
                      input bit a, input int l);
    exp_t e;
    e.owner = o;
    e.start = s;
    e.fin   = f;
    e.abrt  = a;
    e.lead  = l;
    sb.push_back(e);
  endtask

  task automatic close_tenure(input bit ab, input int fin);
    exp_t e;
    int   bad;
    int   o;
    o = -1;
    for (int i = 0; i < 4; i++) if (cur_g[i]) o = i;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tenure_unexpected: owner %0d start %0d end %0d, none queued",
               o, st, fin);
    end else begin
      e = sb.pop_front();
      chk("owner", o, e.owner);
      chk("start_cycle", st, e.start);
      chk("end_cycle", fin, e.fin);
      chk("aborted", int'(ab), int'(e.abrt));
      bad = 0;
      foreach (sq[k]) if (sq[k] != snd_m(e.owner, k - e.lead)) bad++;
      chk("sound_bits_wrong", bad, 0);
      chk("busy_low_in_tenure", busy_bad, 0);
    end
    sq.delete();
    busy_bad = 0;
    cur_g    = '0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      if (cur_g != '0) close_tenure(1'b1, cyc - 1);
    end else begin
      if (cur_g != '0 && grant != cur_g) close_tenure(1'b1, cyc - 1);
      if (cur_g == '0 && grant != '0) begin
        cur_g = grant;
        st    = cyc;
        chk("grant_onehot", $countones(grant), 1);
      end
      if (cur_g != '0) begin
        sq.push_back(sound);
        if (!busy) busy_bad++;
      end
      if (done) begin
        if (cur_g == '0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_without_grant: done=1 with grant 0 at cycle %0d", cyc);
        end else begin
          close_tenure(1'b0, cyc);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] m);
    int t;
    t = cyc + 2;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        push(i, t, t + plen(i), 1'b0, 0);
        t = t + plen(i) + 2;
      end
    end
    req = req | m;
  endtask

  task automatic run(input int keep, input int budget);
    int n;
    bit kept;
    n    = 0;
    kept = 1'b0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      if (kept) begin
        chk("gap_grant", int'(grant), 0);
        chk("gap_busy", int'(busy), 1);
        chk("gap_sound", int'(sound), 0);
        kept = 1'b0;
      end
      if (done) begin
        if (keep > 0) begin
          keep--;
          kept = 1'b1;
        end else begin
          req = req & ~grant;
        end
      end
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: %0d expectations pending after %0d cycles",
               sb.size(), n);
      sb.delete();
      req = '0;
    end
    @(negedge clk);
  endtask

  initial begin
    int c;
    int p;
    logic [3:0] m;
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    chk("reset_grant", int'(grant), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_sound", int'(sound), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(4'b0010);
    run(0, 500);

    issue(4'b0110);
    run(0, 1000);

    issue(4'b1000);
    run(0, 500);

    c   = cyc;
    req = 4'b0100;
    repeat (7) @(negedge clk);
    p = cyc;
`ifdef BUZZER_PREEMPT_EN
    push(2, c + 2, p, 1'b1, 0);
    push(0, p + 1, p + 2 + plen(0), 1'b0, 1);
    push(2, p + 4 + plen(0), p + 4 + plen(0) + plen(2), 1'b0, 0);
`else
    push(2, c + 2, c + 2 + plen(2), 1'b0, 0);
    push(0, c + 4 + plen(2), c + 4 + plen(2) + plen(0), 1'b0, 0);
`endif
    req = req | 4'b0001;
    run(0, 1000);

    c = cyc;
    push(1, c + 2, c + 26, 1'b1, 0);
    req = 4'b0010;
    repeat (26) @(negedge clk);
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("rst_async_grant", int'(grant), 0);
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_done", int'(done), 0);
    chk("rst_async_sound", int'(sound), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_grant", int'(grant), 0);
      chk("post_rst_busy", int'(busy), 0);
    end
    chk("post_rst_queue", sb.size(), 0);
    issue(4'b0010);
    run(0, 500);

    c = cyc;
    for (int k = 0; k < 3; k++) begin
      push(3, c + 2 + k * (plen(3) + 2),
           c + 2 + k * (plen(3) + 2) + plen(3), 1'b0, 0);
    end
    req = 4'b1000;
    run(2, 1000);

    for (int r = 0; r < 12; r++) begin
      m = 4'($urandom_range(1, 15));
      issue(m);
      run(0, 3000);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("final_queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/buzzer_sequencer.md
# buzzer_sequencer

Shares one piezo buzzer output between NREQ requesters and plays a fixed beep pattern per requester. Each pattern is a square tone of programmable half-period, gated on and off for a set number of bursts. The block sits between system event sources (alarm, keypad click, error, timer) and the board `sound` pin. It replaces free-running beep generators with an arbitrated, exactly timed sequencer.

## Interface
- `NREQ`, 4: number of requesters, 1..8; index 0 has the highest priority.
- `TICK_DIV`, 50_000: clk cycles per time-base tick (1 ms at 50 MHz).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in NREQ: level request per requester; held high until `done` with matching `grant`.
- `grant` out NREQ: one-hot owner of the buzzer; all zero when idle.
- `busy` out 1: high while a pattern is playing (any state other than IDLE).
- `done` out 1: one-cycle pulse on pattern completion, coincident with the final `grant`.
- `sound` out 1: buzzer drive.

## Operation
- Pattern for requester i comes from the package table `PAT[i]`:
  - `half` (16 b): tone half-period in clk cycles, minimum 1.
  - `on_t` (12 b): burst length in ticks, minimum 1.
  - `off_t` (12 b): gap length in ticks; 0 means no gap.
  - `reps` (4 b): burst count, minimum 1.
- States:
  - IDLE → ARB when `req` ≠ 0.
  - ARB: latch the lowest set index, assert `grant`, load counters → ON.
  - ON: `sound` toggles every `half` cycles, starting at 1. When `on_t` ticks elapse: if bursts remaining > 1, go to OFF, or to ON when `off_t`=0; otherwise go to DONE.
  - OFF: `sound`=0. When `off_t` ticks elapse → ON.
  - DONE: pulse `done` → IDLE.
- The tick prescaler and the tone counter restart on every ON/OFF entry. A phase therefore lasts exactly `t`×`TICK_DIV` cycles.
- Requests are sampled only in IDLE/ARB. Deasserting `req` mid-pattern does not abort the pattern.
- Simultaneous requests: the lowest index wins. Losers keep `req` high and are served in later rounds.
- A requester still holding `req` after `done` is served again. There is no fairness guarantee beyond fixed priority.
- Reset mid-pattern: immediately returns to IDLE and all outputs go to 0.

## Timing
- Reset values: `grant`=0, `busy`=0, `done`=0, `sound`=0, state IDLE.
- `req` rising in IDLE → `grant` and `busy` high 2 cycles later (IDLE→ARB→ON). `sound` goes to 1 on ON entry.
- `sound` edges are spaced exactly `half` cycles apart. `sound` is forced to 0 on exit from ON, even mid half-period.
- Total pattern length: `reps`×`on_t`×`TICK_DIV` + (`reps`−1)×`off_t`×`TICK_DIV` cycles, plus 1 DONE cycle.
- `grant` drops the cycle after `done`. The earliest re-grant is 2 cycles after `done`.
- All outputs are registered.

## Configuration
- `BUZZER_PREEMPT_EN`:
  - Defined: in ON/OFF, a `req` bit with a lower index than the current owner aborts the pattern. The block forces `sound`=0, moves `grant` to the new owner the next cycle, and restarts from ARB.
    - The preempted requester gets no `done`. It is re-served later if its `req` is still high.
  - Undefined: patterns always run to completion.

## Structure
- Package `buzzer_pkg` holds:
  - the state enum;
  - the pattern struct `{half, on_t, off_t, reps}`;
  - the `PAT[0:7]` constant table;
  - the field width constants.
- Sub-module `buzzer_tone`: tick prescaler plus tone toggle counter.
  - Inputs: `clk`, `rst_n`, `restart`, `en`, `half`.
  - Outputs: `tick`, `sound`.
  - The top-level block keeps the FSM, the arbiter and the phase/burst counters.

## Test plan
- Use `TICK_DIV`=10 and `PAT[1]`={`half`=3, `on_t`=2, `off_t`=1, `reps`=2}.
  - Stimulus: `req[1]` pulse.
  - Expected: `grant`=0010 at cycle 2; 20 cycles of toggling every 3; 10 cycles silent; 20 cycles toggling; `done` at cycle 52.
- Stimulus: `req`=0110 in the same cycle.
  - Expected: requester 1 is served first; requester 2 gets `grant` 2 cycles after `done[1]`.
- Stimulus: `off_t`=0, `reps`=3.
  - Expected: continuous 60-cycle burst with no gap; exactly one `done`.
- Stimulus: `rst_n` low during OFF.
  - Expected: all outputs 0 asynchronously; after release, IDLE until the next `req`.
- Stimulus: `req[0]` during requester 2's ON phase.
  - With `BUZZER_PREEMPT_EN`: `grant`=0001 the next cycle and no `done` for requester 2.
  - Without: requester 0 waits for `done[2]`.
- Stimulus: `req[3]` held high continuously.
  - Expected: back-to-back patterns separated by exactly 2 silent cycles, with `busy` low only in IDLE.
